// File: rtl/core_sequencer_if.sv
// Instruction, flag and memory-handshake bundle between the sequencer (master)
// and the core datapath (slave).
interface core_sequencer_if #(
  parameter int IR_WIDTH   = 16,
  parameter int FLAG_WIDTH = 4
);
  logic [IR_WIDTH-1:0]   ir_in;
  logic [IR_WIDTH-1:0]   ir_out;
  logic [FLAG_WIDTH-1:0] flags_in;
  logic [FLAG_WIDTH-1:0] flags_l;
  logic                  mem_req;
  logic                  mem_ready;

  modport master (
    input  ir_in, flags_in, mem_req, mem_ready,
    output ir_out, flags_l
  );

  modport slave (
    output ir_in, flags_in, mem_req, mem_ready,
    input  ir_out, flags_l
  );
endinterface

// File: rtl/core_sequencer.sv
// t16q phase/reset/debug sequencer: prescaled 4-phase instruction timing with
// memory wait states, reset-instruction injection, flag latching, halt and step.
module core_sequencer #(
  parameter int                  CLKDIV      = 0,
  parameter int                  IR_WIDTH    = 16,
  parameter int                  FLAG_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0] RESET_IR    = 16'h2F02,
  parameter int                  RESET_HOLD  = 2,
  parameter int                  COUNT_WIDTH = 32
) (
  input  logic                   clkin,
  input  logic                   reset,
  core_sequencer_if.master       bus,
  input  logic                   halt,
  input  logic                   step,
  output logic                   ph0,
  output logic                   ph1,
  output logic                   phase_en,
  output logic                   cycle_done,
  output logic                   reset_l,
  output logic                   halted,
  output logic                   stalled,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam int              PW        = (CLKDIV > 0) ? CLKDIV : 1;
  localparam logic [PW-1:0]   PRESC_MAX = {PW{CLKDIV != 0}};
  localparam int              HW        = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RESET_HOLD - 1);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_WAIT, S_HALTED} state_t;

  state_t        state;
  logic [1:0]    phase;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold_cnt;
  logic          rst_meta;
  logic          step_q;

  logic tick, wait_enter, advance, cyc_end, go_halt, step_rise;

  always_comb begin
    tick       = (state == S_RUN) && (presc == PRESC_MAX);
    wait_enter = tick && phase[0] && bus.mem_req && !bus.mem_ready;
    advance    = (tick && !wait_enter) || ((state == S_WAIT) && bus.mem_ready);
    cyc_end    = advance && (phase == 2'b11);
    go_halt    = cyc_end && !reset_l && halt;
    step_rise  = step && !step_q;
  end

  assign ph0        = phase[0];
  assign ph1        = phase[1];
  assign bus.ir_out = reset_l ? RESET_IR : bus.ir_in;

  // rst_meta is the first synchroniser stage; the RESET->RUN transition of the
  // state register acts as the second, so RUN is entered on the second edge.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state       <= S_RESET;
      phase       <= '0;
      presc       <= '0;
      hold_cnt    <= '0;
      rst_meta    <= 1'b0;
      step_q      <= 1'b0;
      phase_en    <= 1'b0;
      cycle_done  <= 1'b0;
      reset_l     <= 1'b1;
      halted      <= 1'b0;
      stalled     <= 1'b0;
      cycle_count <= '0;
      bus.flags_l <= '0;
    end else begin
      rst_meta   <= 1'b1;
      step_q     <= step;
      phase_en   <= advance;
      cycle_done <= cyc_end;

      if (advance) phase <= phase + 2'd1;
      if (advance && (phase == 2'b01)) bus.flags_l <= bus.flags_in;

      if (cyc_end) begin
        cycle_count <= cycle_count + 1'b1;
        if (reset_l) begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) reset_l <= 1'b0;
        end
      end

      // A stepped cycle needs no extra flag: it ends through the same
      // cycle-end halt check that returns to HALTED while halt is held.
      case (state)
        S_RESET: if (rst_meta) state <= S_RUN;
        S_RUN: begin
          if (wait_enter) begin
            state   <= S_WAIT;
            stalled <= 1'b1;
          end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (go_halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (bus.mem_ready) begin
            presc   <= '0;
            stalled <= 1'b0;
            if (go_halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_HALTED: begin
          if (!halt || step_rise) begin
            state  <= S_RUN;
            halted <= 1'b0;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: a CLKDIV=2 instance for phase timing
// and a CLKDIV=0, COUNT_WIDTH=4 instance for waits, flags, debug and wrap.
module tb_core_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, halt_a, step_a, ph0_a, ph1_a, pe_a, cd_a, rl_a, hd_a, st_a;
  logic [31:0] cnt_a;
  logic rst_b, halt_b, step_b, ph0_b, ph1_b, pe_b, cd_b, rl_b, hd_b, st_b;
  logic [3:0] cnt_b;

  core_sequencer_if #(.IR_WIDTH(16), .FLAG_WIDTH(4)) bus_a ();
  core_sequencer_if #(.IR_WIDTH(16), .FLAG_WIDTH(4)) bus_b ();

  core_sequencer #(.CLKDIV(2)) u_a (
    .clkin(clk), .reset(rst_a), .bus(bus_a), .halt(halt_a), .step(step_a),
    .ph0(ph0_a), .ph1(ph1_a), .phase_en(pe_a), .cycle_done(cd_a),
    .reset_l(rl_a), .halted(hd_a), .stalled(st_a), .cycle_count(cnt_a)
  );

  core_sequencer #(.CLKDIV(0), .COUNT_WIDTH(4)) u_b (
    .clkin(clk), .reset(rst_b), .bus(bus_b), .halt(halt_b), .step(step_b),
    .ph0(ph0_b), .ph1(ph1_b), .phase_en(pe_b), .cycle_done(cd_b),
    .reset_l(rl_b), .halted(hd_b), .stalled(st_b), .cycle_count(cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) tick();
    n_tests++; if ({ph1_a, ph0_a, pe_a, cd_a, hd_a, st_a} !== 6'b0) begin
      n_fail++; $display("FAIL reset_a_bits got %b want 000000", {ph1_a, ph0_a, pe_a, cd_a, hd_a, st_a}); end
    n_tests++; if (rl_a !== 1'b1) begin n_fail++; $display("FAIL reset_a_reset_l got %b want 1", rl_a); end
    n_tests++; if (cnt_a !== 32'd0) begin n_fail++; $display("FAIL reset_a_count got %0d want 0", cnt_a); end
    n_tests++; if (bus_a.ir_out !== 16'h2F02) begin
      n_fail++; $display("FAIL reset_a_ir got %h want 2f02", bus_a.ir_out); end
    n_tests++; if ({ph1_b, ph0_b, pe_b, cd_b, hd_b, st_b} !== 6'b0) begin
      n_fail++; $display("FAIL reset_b_bits got %b want 000000", {ph1_b, ph0_b, pe_b, cd_b, hd_b, st_b}); end
    n_tests++; if (bus_b.flags_l !== 4'h0) begin
      n_fail++; $display("FAIL reset_b_flags got %h want 0", bus_b.flags_l); end
    n_tests++; if (rl_b !== 1'b1) begin n_fail++; $display("FAIL reset_b_reset_l got %b want 1", rl_b); end
  endtask

  task automatic test_prescale();
    logic [1:0] exp_q[$];
    logic [1:0] exp_ph;
    logic       exp_rl;
    logic [15:0] exp_ir;
    int cyc, last_pe, last_cd, n_done;
    for (int i = 1; i <= 12; i++) exp_q.push_back(2'(i % 4));
    cyc = 0; last_pe = -1; last_cd = -1; n_done = 0;
    rst_a = 1'b1;
    while (exp_q.size() != 0 && cyc < 300) begin
      tick(); cyc++;
      if (cd_a) begin
        n_done++;
        if (last_cd >= 0) begin
          n_tests++; if (cyc - last_cd != 16) begin
            n_fail++; $display("FAIL prescale_cycle_len got %0d want 16", cyc - last_cd); end
        end
        last_cd = cyc;
      end
      if (pe_a) begin
        exp_ph = exp_q.pop_front();
        exp_rl = (n_done < 2);
        exp_ir = exp_rl ? 16'h2F02 : bus_a.ir_in;
        n_tests++; if ({ph1_a, ph0_a} !== exp_ph) begin
          n_fail++; $display("FAIL prescale_phase got %b want %b", {ph1_a, ph0_a}, exp_ph); end
        n_tests++; if ((last_pe < 0) ? (cyc != 6) : (cyc - last_pe != 4)) begin
          n_fail++; $display("FAIL prescale_phase_len got %0d want %0d", (last_pe < 0) ? cyc : cyc - last_pe,
                             (last_pe < 0) ? 6 : 4); end
        last_pe = cyc;
        n_tests++; if (rl_a !== exp_rl) begin
          n_fail++; $display("FAIL prescale_reset_l got %b want %b", rl_a, exp_rl); end
        n_tests++; if (bus_a.ir_out !== exp_ir) begin
          n_fail++; $display("FAIL prescale_ir_out got %h want %h", bus_a.ir_out, exp_ir); end
      end
    end
    n_tests++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL prescale_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wait();
    logic [3:0] flag_q[$];
    logic [3:0] exp_f;
    int guard, n01, nst;
    rst_b = 1'b1;
    guard = 0; while (rl_b !== 1'b0 && guard < 100) begin tick(); guard++; end
    n_tests++; if (rl_b !== 1'b0) begin n_fail++; $display("FAIL wait_hold_release got %b want 0", rl_b); end
    n_tests++; if (bus_b.ir_out !== 16'hBEEF) begin
      n_fail++; $display("FAIL wait_ir_follow got %h want beef", bus_b.ir_out); end
    bus_b.flags_in = 4'hA; flag_q.push_back(4'hA);
    guard = 0; while ({ph1_b, ph0_b} !== 2'b01 && guard < 20) begin tick(); guard++; end
    bus_b.mem_req = 1'b1; bus_b.mem_ready = 1'b0;
    n01 = 1; nst = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (st_b) nst++;
      if ({ph1_b, ph0_b} != 2'b01) break;
      n01++;
      if (nst == 3) bus_b.mem_ready = 1'b1;
    end
    bus_b.mem_req = 1'b0; bus_b.mem_ready = 1'b0;
    n_tests++; if (nst != 3) begin n_fail++; $display("FAIL wait_stall_len got %0d want 3", nst); end
    n_tests++; if (n01 != 4) begin n_fail++; $display("FAIL wait_phase01_len got %0d want 4", n01); end
    n_tests++; if ({ph1_b, ph0_b, pe_b, st_b} !== 4'b1010) begin
      n_fail++; $display("FAIL wait_exit got %b want 1010", {ph1_b, ph0_b, pe_b, st_b}); end
    exp_f = flag_q.pop_front();
    n_tests++; if (bus_b.flags_l !== exp_f) begin
      n_fail++; $display("FAIL wait_flag_capture got %h want %h", bus_b.flags_l, exp_f); end
    bus_b.flags_in = 4'h5;
    tick(); tick();
    n_tests++; if ({ph1_b, ph0_b} !== 2'b00) begin
      n_fail++; $display("FAIL wait_phase_after got %b want 00", {ph1_b, ph0_b}); end
    n_tests++; if (bus_b.flags_l !== exp_f) begin
      n_fail++; $display("FAIL wait_flag_hold got %h want %h", bus_b.flags_l, exp_f); end
  endtask

  task automatic test_halt_step();
    logic [3:0] cnt_q[$];
    logic [3:0] exp_c;
    int guard, npe, ncd, n;
    guard = 0; while ({ph1_b, ph0_b} !== 2'b10 && guard < 20) begin tick(); guard++; end
    halt_b = 1'b1; cnt_q.push_back(cnt_b + 4'd1);
    guard = 0; while (cd_b !== 1'b1 && guard < 20) begin tick(); guard++; end
    exp_c = cnt_q.pop_front();
    n_tests++; if ({cd_b, hd_b, ph1_b, ph0_b} !== 4'b1100) begin
      n_fail++; $display("FAIL halt_entry got %b want 1100", {cd_b, hd_b, ph1_b, ph0_b}); end
    n_tests++; if (cnt_b !== exp_c) begin n_fail++; $display("FAIL halt_count got %h want %h", cnt_b, exp_c); end
    npe = 0;
    repeat (6) begin tick(); if (pe_b) npe++; end
    n_tests++; if (npe != 0 || hd_b !== 1'b1) begin
      n_fail++; $display("FAIL halt_hold got pe=%0d halted=%b want pe=0 halted=1", npe, hd_b); end
    cnt_q.push_back(cnt_b + 4'd1);
    step_b = 1'b1; tick(); step_b = 1'b0;
    n_tests++; if (hd_b !== 1'b0) begin n_fail++; $display("FAIL step_leave got %b want 0", hd_b); end
    ncd = 0;
    repeat (12) begin
      tick();
      if (cd_b) begin
        ncd++;
        if (cnt_q.size() != 0) begin
          exp_c = cnt_q.pop_front();
          n_tests++; if (cnt_b !== exp_c) begin
            n_fail++; $display("FAIL step_count got %h want %h", cnt_b, exp_c); end
        end
      end
    end
    n_tests++; if (ncd != 1 || hd_b !== 1'b1) begin
      n_fail++; $display("FAIL step_once got done=%0d halted=%b want done=1 halted=1", ncd, hd_b); end
    halt_b = 1'b0; n = 0;
    while (pe_b !== 1'b1 && n < 20) begin tick(); n++; end
    n_tests++; if (n != 2) begin n_fail++; $display("FAIL unhalt_latency got %0d want 2", n); end
  endtask

  task automatic test_halt_in_hold();
    int guard, ndone;
    rst_b = 1'b0; tick();
    halt_b = 1'b1; rst_b = 1'b1;
    ndone = 0; guard = 0;
    while (hd_b !== 1'b1 && guard < 100) begin tick(); guard++; if (cd_b) ndone++; end
    n_tests++; if (ndone != 3 || rl_b !== 1'b0) begin
      n_fail++; $display("FAIL hold_halt got done=%0d reset_l=%b want done=3 reset_l=0", ndone, rl_b); end
    n_tests++; if ({hd_b, ph1_b, ph0_b} !== 3'b100) begin
      n_fail++; $display("FAIL hold_halt_state got %b want 100", {hd_b, ph1_b, ph0_b}); end
    halt_b = 1'b0;
    tick();
  endtask

  task automatic test_async_reset_wait();
    int guard;
    rst_b = 1'b0; tick();
    rst_b = 1'b1; halt_b = 1'b0; bus_b.flags_in = 4'hC;
    guard = 0; while (rl_b !== 1'b0 && guard < 100) begin tick(); guard++; end
    guard = 0; while ({ph1_b, ph0_b} !== 2'b11 && guard < 20) begin tick(); guard++; end
    bus_b.mem_req = 1'b1; bus_b.mem_ready = 1'b0;
    tick();
    n_tests++; if ({st_b, ph1_b, ph0_b} !== 3'b111) begin
      n_fail++; $display("FAIL areset_pre_wait got %b want 111", {st_b, ph1_b, ph0_b}); end
    n_tests++; if (bus_b.flags_l !== 4'hC || cnt_b !== 4'd2) begin
      n_fail++; $display("FAIL areset_pre_state got flags=%h cnt=%h want flags=c cnt=2", bus_b.flags_l, cnt_b); end
    #2 rst_b = 1'b0;
    #1;
    n_tests++; if ({ph1_b, ph0_b, st_b, pe_b, cd_b, hd_b} !== 6'b0) begin
      n_fail++; $display("FAIL areset_bits got %b want 000000", {ph1_b, ph0_b, st_b, pe_b, cd_b, hd_b}); end
    n_tests++; if (cnt_b !== 4'd0 || bus_b.flags_l !== 4'h0) begin
      n_fail++; $display("FAIL areset_clear got cnt=%h flags=%h want 0 0", cnt_b, bus_b.flags_l); end
    n_tests++; if (rl_b !== 1'b1 || bus_b.ir_out !== 16'h2F02) begin
      n_fail++; $display("FAIL areset_ir got reset_l=%b ir=%h want 1 2f02", rl_b, bus_b.ir_out); end
    bus_b.mem_req = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [3:0] cnt_q[$];
    logic [3:0] exp_c;
    int guard;
    for (int i = 1; i <= 17; i++) cnt_q.push_back(4'(i));
    rst_b = 1'b1;
    guard = 0;
    while (cnt_q.size() != 0 && guard < 200) begin
      tick(); guard++;
      if (cd_b) begin
        exp_c = cnt_q.pop_front();
        n_tests++; if (cnt_b !== exp_c) begin
          n_fail++; $display("FAIL wrap_count got %h want %h", cnt_b, exp_c); end
      end
    end
    n_tests++; if (cnt_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_timeout got %0d left want 0", cnt_q.size()); end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    halt_a = 1'b0; step_a = 1'b0; halt_b = 1'b0; step_b = 1'b0;
    bus_a.ir_in = 16'h1234; bus_a.flags_in = 4'h0; bus_a.mem_req = 1'b0; bus_a.mem_ready = 1'b0;
    bus_b.ir_in = 16'hBEEF; bus_b.flags_in = 4'h0; bus_b.mem_req = 1'b0; bus_b.mem_ready = 1'b0;
    test_reset();
    test_prescale();
    test_wait();
    test_halt_step();
    test_halt_in_hold();
    test_async_reset_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Parametrised timing and control sequencer for the t16q core. It generates the two-bit instruction phase (`ph1`,`ph0`) from `clkin` with a configurable prescaler and stretches memory phases with wait states. It also sequences reset, including injection of the reset instruction, latches ALU flags at the correct phase boundary, and adds halt and single-step debug control. It replaces the fixed clock generation and reset/flag latching currently embedded in `Core`, and feeds `Decode`, `Registers`, `MMU` and the debug outputs.

## Interface
- `CLKDIV`, 0: each phase lasts 2^CLKDIV `clkin` cycles. Legal range 0..24.
- `IR_WIDTH`, 16: width of the instruction word.
- `FLAG_WIDTH`, 4: width of the ALU flag vector.
- `RESET_IR`, 16'h2F02: instruction forced while in reset ("B 0").
- `RESET_HOLD`, 2: number of completed instruction cycles that `reset_l` stays high after reset release. Minimum 1.
- `COUNT_WIDTH`, 32: width of the retired-cycle counter.
- `clkin` in 1: the only clock.
- `reset` in 1: **asynchronous, active-low** reset.
- `ir_in` in IR_WIDTH: instruction register from `Registers`.
- `flags_in` in FLAG_WIDTH: unlatched ALU flags.
- `mem_req` in 1: current phase performs a memory access.
- `mem_ready` in 1: memory has completed the access.
- `halt` in 1: level-sensitive debug halt request.
- `step` in 1: debug single-step request; rising edge is detected internally.
- `ph0`, `ph1` out 1 each: phase bits. Sequence {ph1,ph0} = 00, 01, 10, 11.
- `phase_en` out 1: one-`clkin` strobe on every phase advance.
- `cycle_done` out 1: one-`clkin` strobe when the 11 -> 00 advance occurs.
- `ir_out` out IR_WIDTH: equals `RESET_IR` when `reset_l` is high, otherwise `ir_in`. Combinational.
- `flags_l` out FLAG_WIDTH: latched flags.
- `reset_l` out 1: core-level reset indication, active-high.
- `halted` out 1: high while in the HALTED state.
- `stalled` out 1: high while in the WAIT state.
- `cycle_count` out COUNT_WIDTH: count of completed instruction cycles. Wraps modulo 2^COUNT_WIDTH.

## Operation
- States: RESET, RUN, WAIT, HALTED.
- Reset assertion takes effect immediately, from any state and mid-phase. It sets state = RESET, phase = 00, prescaler = 0, `flags_l` = 0, `cycle_count` = 0, `reset_l` = 1, all strobes = 0, `halted` = 0, `stalled` = 0, and clears the hold counter and step edge detector.
- Reset release passes through a 2-flop synchroniser. RESET moves to RUN on the second `clkin` edge after release.
- RUN:
  - The prescaler counts 0..2^CLKDIV−1. A tick occurs at the terminal count; with CLKDIV = 0 every clock is a tick.
  - On a tick, if ph0 = 1, `mem_req` = 1 and `mem_ready` = 0, the state moves to WAIT with no phase advance and the prescaler frozen at its terminal count.
  - Otherwise on a tick the phase advances and `phase_en` pulses.
- WAIT:
  - Holds the phase.
  - On the first clock that samples `mem_ready` = 1, the phase advances, `phase_en` pulses, the state returns to RUN and the prescaler resets to 0.
- Flag latch: `flags_l` <= `flags_in` only on the 01 -> 10 advance. It is held at all other times.
- Cycle end (11 -> 00):
  - `cycle_done` pulses and `cycle_count` increments.
  - While `reset_l` = 1, the hold counter increments. When it reaches RESET_HOLD, `reset_l` falls on that same edge.
  - If `reset_l` = 0 and `halt` = 1, the state moves to HALTED; otherwise it stays in RUN.
- Halt is ignored while `reset_l` = 1.
- HALTED:
  - Phase = 00, no strobes, prescaler held at 0.
  - If `halt` = 0, the state moves to RUN on the next clock.
  - A `step` rising edge moves the state to RUN with `step_pending` = 1. At the next cycle end the state returns to HALTED if `halt` is still 1, and `step_pending` clears.
  - Step edges seen outside HALTED are discarded.
- Reset mid-WAIT or mid-step aborts the access. No flag or count update occurs.

## Timing
- Phase duration in RUN is exactly 2^CLKDIV clocks, plus any wait clocks.
- An instruction cycle with no waits lasts 4·2^CLKDIV clocks.
- All outputs are registered except `ir_out`.
- `halted` rises on the clock edge of the final `cycle_done`.
- After halt deassertion, the first `phase_en` occurs 1 + 2^CLKDIV clocks later.
- A simultaneous `mem_ready` = 1 and tick in RUN means no wait is entered.

## Test plan
- CLKDIV = 2, reset released, no `mem_req`:
  - Phases change every 4 clocks and `cycle_done` occurs every 16.
  - `ir_out` = 16'h2F02 and `reset_l` = 1 until the 2nd `cycle_done`, after which `ir_out` follows `ir_in`.
- CLKDIV = 0, `mem_req` = 1 in phase 01, `mem_ready` delayed 3 clocks:
  - `stalled` is high for 3 clocks and phase 01 lasts 4 clocks.
  - `flags_l` captures `flags_in` = 4'hA only on the 01 -> 10 advance; a change to 4'h5 during phase 10 is not captured.
- After reset_l = 0, `halt` raised mid-cycle:
  - The current cycle completes, then `halted` = 1 with phase 00.
  - A single `step` pulse yields exactly one `cycle_done` (count +1) and then HALTED again.
- Halt held during reset hold: no HALTED entry until `reset_l` falls.
- Async reset asserted in WAIT at phase 11: all outputs return to reset values immediately, with `cycle_count` = 0 and `flags_l` = 0.
- COUNT_WIDTH = 4: after 16 cycles `cycle_count` wraps from 4'hF to 0.
